// File: rtl/key_svc_pkg.sv
// Shared types and constants for the key PIO interrupt servicer.
package key_svc_pkg;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    RD    = 3'd2,
    LATCH = 3'd3,
    CLR   = 3'd4,
    PUSH  = 3'd5
  } svc_state_e;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int KEY_IDX_W = 3;
  localparam int MAX_KEYS  = 8;

  function automatic logic [KEY_IDX_W-1:0] lowest_set_idx(input logic [MAX_KEYS-1:0] bits);
    logic [KEY_IDX_W-1:0] idx;
    idx = {KEY_IDX_W{1'b0}};
    for (int i = MAX_KEYS - 1; i >= 0; i--) begin
      if (bits[i]) begin
        idx = KEY_IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word-fall-through event FIFO with occupancy count; head reads as zero when empty.
module key_event_fifo
  import key_svc_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 19
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign count     = count_r;
  assign pop_data  = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // Storage array
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/key_irq_servicer.sv
// Avalon-MM master that programs the key PIO mask, services its interrupt and
// queues one timestamped event per captured key edge.
module key_irq_servicer
  import key_svc_pkg::*;
#(
  parameter int              KEY_W      = 4,
  parameter int              FIFO_DEPTH = 8,
  parameter int              TS_W       = 16,
  parameter logic [KEY_W-1:0] MASK_INIT = 4'hF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  output logic [1:0]                    pio_address,
  output logic                          pio_chipselect,
  output logic                          pio_write_n,
  output logic [31:0]                   pio_writedata,
  input  logic [31:0]                   pio_readdata,
  input  logic                          pio_irq,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [TS_W+KEY_IDX_W-1:0]     ev_data,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          overflow,
  input  logic                          ovf_clr
);
  localparam int EV_W = TS_W + KEY_IDX_W;

  svc_state_e           state_r, next_state_s;
  logic [KEY_W-1:0]     pend_r, pend_next_s;
  logic [TS_W-1:0]      ts_r, ts_l_r;
  logic                 skip_r, overflow_r;
  logic [1:0]           addr_r, addr_next_s;
  logic                 cs_r, cs_next_s;
  logic                 wn_r, wn_next_s;
  logic [31:0]          wd_r, wd_next_s;
  logic                 push_s, fifo_push_s, drop_s;
  logic                 fifo_full_s, fifo_empty_s;
  logic [KEY_IDX_W-1:0] push_idx_s;
  logic [EV_W-1:0]      push_data_s;
  logic                 unused_rd_s;

  assign push_idx_s  = lowest_set_idx(MAX_KEYS'(pend_r));
  assign push_data_s = {ts_l_r, push_idx_s};
  assign fifo_push_s = push_s && !fifo_full_s;
  assign drop_s      = push_s && fifo_full_s;
  assign unused_rd_s = ^pio_readdata[31:KEY_W];

  // Bus registers hold the access for the coming cycle; the mask write is
  // launched from INIT so the bus itself is idle straight out of reset.
  always_comb begin
    next_state_s = state_r;
    pend_next_s  = pend_r;
    addr_next_s  = ADDR_DATA;
    cs_next_s    = 1'b0;
    wn_next_s    = 1'b1;
    wd_next_s    = 32'h0000_0000;
    push_s       = 1'b0;
    case (state_r)
      INIT: begin
        next_state_s = IDLE;
        addr_next_s  = ADDR_MASK;
        cs_next_s    = 1'b1;
        wn_next_s    = 1'b0;
        wd_next_s    = 32'(MASK_INIT);
      end
      IDLE: begin
        // skip_r masks the stale irq the PIO still shows right after the clear
        if (pio_irq && enable && !skip_r) begin
          next_state_s = RD;
          addr_next_s  = ADDR_EDGE;
        end else begin
          next_state_s = IDLE;
        end
      end
      RD: begin
        next_state_s = LATCH;
      end
      LATCH: begin
        next_state_s = CLR;
        pend_next_s  = pio_readdata[KEY_W-1:0];
        addr_next_s  = ADDR_EDGE;
        cs_next_s    = 1'b1;
        wn_next_s    = 1'b0;
      end
      CLR: begin
        if (pend_r != {KEY_W{1'b0}}) begin
          next_state_s = PUSH;
        end else begin
          next_state_s = IDLE;
        end
      end
      PUSH: begin
        push_s      = 1'b1;
        pend_next_s = pend_r & (pend_r - KEY_W'(1));
        if (pend_next_s == {KEY_W{1'b0}}) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = PUSH;
        end
      end
      default: begin
        next_state_s = INIT;
      end
    endcase
  end

  // FSM, pending bits, timestamp and bus registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= INIT;
      pend_r  <= {KEY_W{1'b0}};
      ts_r    <= {TS_W{1'b0}};
      ts_l_r  <= {TS_W{1'b0}};
      skip_r  <= 1'b0;
      addr_r  <= ADDR_DATA;
      cs_r    <= 1'b0;
      wn_r    <= 1'b1;
      wd_r    <= 32'h0000_0000;
    end else begin
      state_r <= next_state_s;
      pend_r  <= pend_next_s;
      ts_r    <= ts_r + TS_W'(1);
      if (state_r == LATCH) begin
        ts_l_r <= ts_r;
      end
      skip_r  <= (state_r == CLR);
      addr_r  <= addr_next_s;
      cs_r    <= cs_next_s;
      wn_r    <= wn_next_s;
      wd_r    <= wd_next_s;
    end
  end

  // Sticky overflow; a drop beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (ovf_clr) begin
      overflow_r <= 1'b0;
    end
  end

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EV_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push_s),
    .push_data (push_data_s),
    .pop       (ev_ready),
    .pop_data  (ev_data),
    .count     (ev_count),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign ev_valid       = !fifo_empty_s;
  assign overflow       = overflow_r;
  assign pio_address    = addr_r;
  assign pio_chipselect = cs_r;
  assign pio_write_n    = wn_r;
  assign pio_writedata  = wd_r;

endmodule

// File: doc/key_irq_servicer.md
Name: key_irq_servicer

Overview:
- Hardware Avalon-MM master that owns the 4-bit push-button PIO slave (in_port, irq_mask at address 2, edge_capture at address 3).
- Programs the PIO interrupt mask after reset.
- On PIO irq: reads edge_capture, clears it, and converts each set bit into a timestamped key event.
- Events go into a small FIFO drained by a valid/ready consumer (UI logic or a CPU-facing CSR block), so software never services the key PIO directly.

Parameters:
- KEY_W, 4, number of keys / PIO data width (1..8).
- FIFO_DEPTH, 8, event FIFO entries (power of 2, >=2).
- TS_W, 16, width of free-running timestamp counter.
- MASK_INIT, 4'hF, value written to PIO irq_mask after reset (KEY_W bits).

Ports:
- clk  in  1  system clock, shared with the PIO.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  servicing enable; when 0, irq is ignored (the post-reset mask write still occurs).
- pio_address  out  2  to PIO address.
- pio_chipselect  out  1  to PIO chipselect.
- pio_write_n  out  1  to PIO write_n (active low).
- pio_writedata  out  32  to PIO writedata.
- pio_readdata  in  32  from PIO; registered, reflects pio_address of the previous cycle.
- pio_irq  in  1  from PIO irq.
- ev_valid  out  1  FIFO head valid.
- ev_ready  in  1  consumer pops the head when ev_valid && ev_ready.
- ev_data  out  TS_W+3  {timestamp[TS_W-1:0], key_idx[2:0]}.
- ev_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; set when an event is dropped.
- ovf_clr  in  1  clears overflow.

Behaviour:
- Reset (sync, high) values:
  - pio_address=0, pio_chipselect=0, pio_write_n=1, pio_writedata=0.
  - FIFO emptied: ev_valid=0, ev_count=0, ev_data=0.
  - overflow=0, timestamp=0, FSM=INIT.
- Timestamp: increments every cycle and wraps modulo 2^TS_W.
- Idle bus: address=0, chipselect=0, write_n=1, writedata=0.
- FSM, one state per cycle unless noted:
  - INIT: chipselect=1, write_n=0, address=2, writedata=MASK_INIT zero-extended. Next state IDLE.
  - IDLE: idle bus. If pio_irq && enable, go to RD.
  - RD: address=3, chipselect=0, write_n=1. Next state LATCH.
  - LATCH: pend <= pio_readdata[KEY_W-1:0]; ts_l <= timestamp. Next state CLR.
  - CLR: chipselect=1, write_n=0, address=3, writedata=0. This clears all edge_capture bits. Next state PUSH if pend!=0, else IDLE.
  - PUSH: each cycle, push the lowest set bit of pend as {ts_l, idx} and clear that bit in pend. When the last bit is pushed, go to IDLE.
- Latency: irq observed in IDLE at cycle t -> first event visible on ev_valid at t+5.
- Edges that land in edge_capture between the LATCH sample and the CLR write are lost. This is an accepted limitation of the PIO clear-all semantics.
- The irq stays high for one cycle after CLR (registered in the PIO). IDLE must therefore ignore pio_irq for the first cycle after CLR to avoid a spurious zero-read service.
- Push into a full FIFO:
  - Fullness is judged on occupancy at the start of the cycle; a same-cycle pop does not make room.
  - The event is dropped and overflow is set. The FSM does not stall.
- Same-cycle ovf_clr and a new drop: set wins.
- Same-cycle push and pop (not full): ev_count is unchanged.
- FIFO read is first-word-fall-through: ev_data is valid whenever ev_valid=1. Pointers wrap modulo FIFO_DEPTH.
- enable deasserted mid-service: the current service completes; new irqs are then ignored.
- Reset mid-operation: returns to INIT next cycle. The mask is re-written, any partial pend is discarded, and the FIFO is flushed.

Decomposition:
- Package key_svc_pkg holds:
  - FSM state enum {INIT, IDLE, RD, LATCH, CLR, PUSH}.
  - PIO register constants ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3.
  - Event field widths.
- Sub-module key_event_fifo: synchronous FWFT FIFO with push/pop/count/full/empty, sync active-high reset. Overflow detection stays in the parent.

Test Plan (bench uses a behavioural model of the PIO, falling-edge capture on in_port):
1. Reset release -> the cycle after, chipselect=1, write_n=0, address=2, writedata=0x0000000F; no other PIO write until irq; ev_valid=0.
2. in_port bit2 1->0 with mask 0xF -> after the sequence RD(addr 3), LATCH, CLR(write addr 3), one event with key_idx=2 and timestamp = counter at LATCH; PIO edge_capture=0; ev_count=1.
3. Bits 0 and 3 falling in the same cycle -> two events on consecutive push cycles, idx 0 then idx 3, identical timestamps.
4. ev_ready=0, nine separate single-key services with FIFO_DEPTH=8 -> ev_count=8, overflow=1, the first 8 events retained in order. Pulse ovf_clr -> overflow=0. Pop all -> ev_valid=0.
5. enable=0 with pio_irq high for 100 cycles -> no PIO accesses. Raise enable -> service starts within 1 cycle and the event appears.
6. Assert reset during PUSH with 2 bits pending -> next cycle ev_valid=0, ev_count=0, state INIT; the following cycle re-writes the mask with 0xF.
